// File: rtl/spi_byte_phy.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) byte-level slave PHY with pin synchronisers.
// Define SPI_PHY_BIT_ERR_EN to build the sticky framing/setup error flag on bit_err.
module spi_byte_phy #(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SCLK,
  input  logic            SS,
  input  logic            MOSI,
  output logic            MISO,
  output logic            miso_oe,
  input  logic [BITS-1:0] tx_data,
  output logic            tx_load,
  output logic [BITS-1:0] rx_byte,
  output logic            rx_valid,
  output logic            frame_start,
  output logic            frame_end,
  output logic            busy,
  output logic            bit_err
);
  localparam int         CW    = $clog2(BITS + 1);
  localparam logic [2:0] FLUSH = 3'(SYNC_STAGES + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, ss_hist_q;
  logic [2:0]             flush_q, flush_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [BITS-2:0]        rx_sr_q, rx_sr_d;
  logic [BITS-1:0]        tx_sr_q, tx_sr_d;
  logic [BITS-1:0]        rx_byte_q, rx_byte_d;
  logic                   byte_done_q, byte_done_d;
  logic                   miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;
  logic                   tx_load_q, tx_load_d, rx_valid_q, rx_valid_d;
  logic                   fs_q, fs_d, fe_q, fe_d;
  logic                   sclk_s, ss_s, mosi_s, armed;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [BITS-1:0]        rx_shifted;
`ifdef SPI_PHY_BIT_ERR_EN
  logic                   bit_err_q, bit_err_d;
  logic [1:0]             setup_q, setup_d;
`endif

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  // After reset the SS chain is flushed before falls count, so an SS already low is not a frame start.
  assign armed     = (flush_q == FLUSH);
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_rise   = ss_s & ~ss_hist_q;
  assign ss_fall   = armed & ~ss_s & ss_hist_q;
  assign rx_shifted = {rx_sr_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    flush_d     = armed ? flush_q : flush_q + 3'd1;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rx_byte_d   = rx_byte_q;
    byte_done_d = byte_done_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    tx_load_d   = 1'b0;
    rx_valid_d  = 1'b0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          fs_d        = 1'b1;
          tx_load_d   = 1'b1;
          tx_sr_d     = tx_data;
          miso_d      = tx_data[BITS-1];
          busy_d      = 1'b1;
          oe_d        = 1'b1;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
          rx_sr_d     = '0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          fe_d      = 1'b1;
          busy_d    = 1'b0;
          oe_d      = 1'b0;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_sr_d = rx_shifted[BITS-2:0];
          if (bit_cnt_q == CW'(BITS - 1)) begin
            rx_byte_d   = rx_shifted;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0 && byte_done_q) begin
            tx_load_d = 1'b1;
            tx_sr_d   = tx_data;
            miso_d    = tx_data[BITS-1];
          end else if (bit_cnt_q != '0) begin
            // A fall before the first rise (SCLK idled high at SS fall) has no bit to advance past.
            tx_sr_d = tx_sr_q << 1;
            miso_d  = tx_sr_q[BITS-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_PHY_BIT_ERR_EN
    bit_err_d = bit_err_q;
    setup_d   = (setup_q != 2'd0) ? setup_q - 2'd1 : 2'd0;
    if (state_q == IDLE && ss_fall) begin
      bit_err_d = 1'b0;
      setup_d   = 2'd2;
    end else if (state_q == ACTIVE) begin
      if (ss_rise) begin
        if (bit_cnt_q != '0) bit_err_d = 1'b1;
      end else if (sclk_rise && setup_q != 2'd0) begin
        bit_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
      flush_q     <= 3'd0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_byte_q   <= '0;
      byte_done_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      tx_load_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
`ifdef SPI_PHY_BIT_ERR_EN
      bit_err_q   <= 1'b0;
      setup_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_s;
      flush_q     <= flush_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rx_byte_q   <= rx_byte_d;
      byte_done_q <= byte_done_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      tx_load_q   <= tx_load_d;
      rx_valid_q  <= rx_valid_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
`ifdef SPI_PHY_BIT_ERR_EN
      bit_err_q   <= bit_err_d;
      setup_q     <= setup_d;
`endif
    end
  end

  assign MISO        = miso_q;
  assign miso_oe     = oe_q;
  assign tx_load     = tx_load_q;
  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign busy        = busy_q;
`ifdef SPI_PHY_BIT_ERR_EN
  assign bit_err     = bit_err_q;
`else
  assign bit_err     = 1'b0;
`endif
endmodule

// File: tb/tb_spi_byte_phy.sv
// Bench for spi_byte_phy: a mode-0 SPI master model drives the pins at f_clk = 8 x SCLK;
// a monitor scoreboards rx bytes while the master checks MISO and strobe counts.
`timescale 1ns/1ps
module tb_spi_byte_phy;
  localparam int SYNC_STAGES = 2;
  localparam int BITS        = 8;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       SCLK = 1'b0;
  logic       SS   = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       MISO, miso_oe, tx_load, rx_valid, frame_start, frame_end, busy, bit_err;
  logic [7:0] rx_byte;

  spi_byte_phy #(.SYNC_STAGES(SYNC_STAGES), .BITS(BITS)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .frame_start(frame_start), .frame_end(frame_end),
    .busy(busy), .bit_err(bit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_fs = 0, n_fe = 0, n_tl = 0, n_rv = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_pend_q[$];
  logic [7:0] frame_mo[$];
  logic [7:0] frame_tx[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid pops one expected byte.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (frame_start) n_fs++;
      if (frame_end)   n_fe++;
      if (tx_load)     n_tl++;
      if (rx_valid) begin
        n_rv++;
        if (exp_rx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid", rx_byte);
        end else begin
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // One SPI bit slot per iteration: 4 clk low (MOSI set), sample MISO, 4 clk high.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit end_ss,
                      input bit ss_with_rise, output logic [7:0] mi, output int lat);
    mi  = 8'h00;
    lat = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      MOSI = mo[i];
      repeat (3) @(negedge clk);
      mi[i] = MISO;
      SCLK = 1'b1;
      if (ss_with_rise && i == 8 - nbits) SS = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (rx_valid) begin
          if (lat == 0) lat = c;
          if (tx_pend_q.size() > 0) tx_data = tx_pend_q.pop_front();
        end
      end
      if (end_ss && i == 8 - nbits) SS = 1'b1;
      SCLK = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [7:0] first_tx);
    tx_data = first_tx;
    @(negedge clk);
    SS = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [15:0] outs();
    return {MISO, miso_oe, tx_load, rx_valid, frame_start, frame_end, busy, bit_err, rx_byte};
  endfunction

  // Full frame from frame_mo / frame_tx; last byte ends with SCLK fall and SS rise together.
  task automatic run_frame(output int last_lat);
    logic [7:0] mi;
    int lat;
    int fs0 = n_fs, fe0 = n_fe, tl0 = n_tl, rv0 = n_rv;
    int nb = frame_mo.size();
    last_lat = 0;
    for (int k = 1; k < frame_tx.size(); k++) tx_pend_q.push_back(frame_tx[k]);
    for (int k = 0; k < nb; k++) exp_rx_q.push_back(frame_mo[k]);
    start_frame(frame_tx[0]);
    chk("busy_active", {31'd0, busy}, 32'd1);
    chk("oe_active", {31'd0, miso_oe}, 32'd1);
    for (int k = 0; k < nb; k++) begin
      xfer(frame_mo[k], 8, (k == nb - 1), 1'b0, mi, lat);
      chk("miso_byte", {24'd0, mi}, {24'd0, frame_tx[k]});
      last_lat = lat;
    end
    repeat (8) @(negedge clk);
    chk("frame_start_cnt", n_fs - fs0, 1);
    chk("frame_end_cnt", n_fe - fe0, 1);
    chk("tx_load_cnt", n_tl - tl0, nb);
    chk("rx_valid_cnt", n_rv - rv0, nb);
    chk("idle_pins", {29'd0, busy, miso_oe, MISO}, 32'd0);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
    tx_pend_q.delete();
  endtask

  initial begin
    logic [7:0] mi;
    int lat;
    int fs0, fe0, tl0, rv0;

    // Reset with pins idle, then 20 quiet cycles.
    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'd0, outs()}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_strobes", n_fs + n_fe + n_tl + n_rv, 0);
    chk("post_reset_outputs", {16'd0, outs()}, 32'd0);

    // Single byte, tx 3C, rx A5, with rx_valid latency.
    frame_mo = '{8'hA5};
    frame_tx = '{8'h3C};
    run_frame(lat);
    chk("rx_latency", lat, SYNC_STAGES + 1);
    chk("rx_byte_hold", {24'd0, rx_byte}, 32'hA5);

    // Three-byte frame with tx_data refreshed after each rx_valid.
    frame_mo = '{8'h01, 8'h80, 8'hFF};
    frame_tx = '{8'h11, 8'h22, 8'h33};
    run_frame(lat);

    // Abort after 5 bits of F0 following a completed 5A.
    fs0 = n_fs; fe0 = n_fe; tl0 = n_tl; rv0 = n_rv;
    exp_rx_q.push_back(8'h5A);
    tx_pend_q.push_back(8'h77);
    start_frame(8'h96);
    xfer(8'h5A, 8, 1'b0, 1'b0, mi, lat);
    chk("abort_miso_first", {24'd0, mi}, 32'h96);
    xfer(8'hF0, 5, 1'b0, 1'b0, mi, lat);
    chk("abort_miso_partial", {24'd0, mi & 8'hF8}, 32'h70);
    repeat (4) @(negedge clk);
    SS = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_rx_valid_cnt", n_rv - rv0, 1);
    chk("abort_rx_byte", {24'd0, rx_byte}, 32'h5A);
    chk("abort_frame_end", n_fe - fe0, 1);
    chk("abort_tx_load", n_tl - tl0, 2);
    chk("abort_oe", {30'd0, miso_oe, busy}, 32'd0);
`ifdef SPI_PHY_BIT_ERR_EN
    chk("abort_bit_err", {31'd0, bit_err}, 32'd1);
`endif
    tx_pend_q.delete();

    // Reset mid-byte with SS held low.
    start_frame(8'hAA);
    xfer(8'h12, 3, 1'b0, 1'b0, mi, lat);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {16'd0, outs()}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fs0 = n_fs;
    repeat (20) @(negedge clk);
    chk("midreset_no_start", n_fs - fs0, 0);
    chk("midreset_idle", {16'd0, outs()}, 32'd0);
    SS = 1'b1;
    repeat (8) @(negedge clk);
    frame_mo = '{8'hC3};
    frame_tx = '{8'h4E};
    run_frame(lat);
    chk("after_reset_rx", {24'd0, rx_byte}, 32'hC3);

    // SS rise lands together with the 8th SCLK rise.
    fe0 = n_fe; tl0 = n_tl; rv0 = n_rv;
    start_frame(8'h5C);
`ifdef SPI_PHY_BIT_ERR_EN
    chk("bit_err_cleared", {31'd0, bit_err}, 32'd0);
`endif
    xfer(8'h99, 8, 1'b0, 1'b1, mi, lat);
    repeat (8) @(negedge clk);
    chk("race_miso", {24'd0, mi}, 32'h5C);
    chk("race_no_rx_valid", n_rv - rv0, 0);
    chk("race_frame_end", n_fe - fe0, 1);
    chk("race_tx_load", n_tl - tl0, 1);
    chk("race_rx_byte", {24'd0, rx_byte}, 32'hC3);
`ifdef SPI_PHY_BIT_ERR_EN
    chk("race_bit_err", {31'd0, bit_err}, 32'd1);
`else
    chk("bit_err_off", {31'd0, bit_err}, 32'd0);
`endif

    // Random frames against the byte-level model: rx equals MOSI bytes, MISO equals tx bytes.
    for (int f = 0; f < 6; f++) begin
      int nb = $urandom_range(1, 3);
      frame_mo.delete();
      frame_tx.delete();
      for (int k = 0; k < nb; k++) begin
        frame_mo.push_back(8'($urandom));
        frame_tx.push_back(8'($urandom));
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
      run_frame(lat);
      chk("rand_latency", lat, SYNC_STAGES + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_byte_phy.md
Name: spi_byte_phy

Overview:
Byte-level SPI slave physical layer, directly upstream of the SPI frame controller. Synchronises the asynchronous SCLK/SS/MOSI pins into the system clock domain and handles SPI mode 0 (CPOL=0, CPHA=0, MSB first). Deserialises MOSI into bytes and serialises one byte per slot onto MISO. Provides per-byte strobes and frame start/end strobes, which the frame controller consumes as EoB/busy.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pin synchronisers (legal range 2..3)
BITS, 8, bits per SPI word

Ports:
clk  in  1  master system clock
rst  in  1  reset; asynchronous, active-low
SCLK  in  1  SPI clock pin (asynchronous)
SS  in  1  slave select pin, active-low (asynchronous)
MOSI  in  1  master-out slave-in pin (asynchronous)
MISO  out  1  master-in slave-out data
miso_oe  out  1  MISO output enable; high only while a frame is active
tx_data  in  BITS  next byte to transmit; sampled on tx_load
tx_load  out  1  one-cycle strobe; tx_data captured into the TX shift register this cycle
rx_byte  out  BITS  last complete received byte; held until the next byte completes
rx_valid  out  1  one-cycle strobe; rx_byte updated this cycle
frame_start  out  1  one-cycle strobe on synchronised SS falling edge
frame_end  out  1  one-cycle strobe on synchronised SS rising edge
busy  out  1  high while the synchronised SS is low
bit_err  out  1  see Optional Feature; tied to 0 when the feature is compiled out

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, synchroniser chains are 0 with SS chain = 1, bit counter is 0, state is IDLE.
- Synchronisers: SYNC_STAGES flops per pin, plus one history flop for edge detection.
- Edge detect latency: SYNC_STAGES+1 clk cycles from pin edge to internal strobe.
- Required ratio: f_clk >= 6 x f_SCLK. No behaviour is guaranteed below this ratio.
- FSM IDLE -> ACTIVE on SS fall:
  - Pulse frame_start.
  - Pulse tx_load and capture tx_data.
  - Set busy=1 and miso_oe=1.
  - Drive MISO with tx_data[BITS-1].
  - Clear bit_cnt.
- ACTIVE, SCLK rising edge:
  - Shift synchronised MOSI into the RX shift register LSB.
  - bit_cnt++.
  - When bit_cnt reaches BITS: on the same cycle, rx_byte <= shifted value, pulse rx_valid, bit_cnt <= 0.
- ACTIVE, SCLK falling edge:
  - If bit_cnt==0 and at least one byte has completed in this frame: pulse tx_load, capture tx_data, drive MISO with its MSB.
  - Otherwise: shift the TX register left and drive the next bit.
  - tx_data must be stable from the rx_valid strobe until tx_load. The upstream has at least 2 clk cycles at the minimum ratio.
- ACTIVE -> IDLE on SS rise:
  - Pulse frame_end; busy=0, miso_oe=0, MISO=0.
  - Discard a partial RX byte with no rx_valid; bit_cnt <= 0.
  - rx_byte keeps its last value.
- SCLK edges are ignored in IDLE.
- Simultaneous SS rise and SCLK edge in the same cycle: the SS rise wins and the SCLK edge is dropped.
- SCLK already high at SS fall: there is no rising edge until SCLK toggles low then high. The first rising edge after SS fall is bit 0.
- No backpressure: rx_valid is a strobe and the consumer must accept it. There is no overrun detection.
- Reset mid-frame: all state is cleared immediately. After reset release, SS is seen as already low, so no frame_start pulses. The block stays IDLE until SS goes high and then low again.

Optional Feature:
Macro SPI_PHY_BIT_ERR_EN.
- Defined:
  - bit_err is a sticky flag, set on frame_end when bit_cnt != 0 (the frame ended off a byte boundary).
  - It is also set when an SCLK rising edge occurs within 2 clk cycles of frame_start (setup violation).
  - It is cleared on the next frame_start or by reset.
- Not defined: bit_err is constant 0 and the related logic is absent.

Test Plan:
1. Reset with pins idle (SS=1, SCLK=0) -> all outputs 0; no strobes for 20 cycles after rst release.
2. tx_data=8'h3C, SS low, master shifts 8'hA5 with f_clk=8xSCLK ->
   - frame_start and tx_load pulse once.
   - MISO bits observed on SCLK rises are 0,0,1,1,1,1,0,0.
   - rx_valid pulses once with rx_byte=8'hA5, SYNC_STAGES+1 cycles after the 8th rise.
3. Three-byte frame: MOSI 8'h01,8'h80,8'hFF; tx_data changed after each rx_valid to 8'h11,8'h22,8'h33 ->
   - 3 rx_valid pulses with the matching bytes.
   - MISO returns 8'h11,8'h22,8'h33.
   - tx_load pulses 3 times; frame_end pulses once.
4. Abort: SS rises after 5 bits of 8'hF0 following a completed 8'h5A ->
   - No extra rx_valid; rx_byte stays 8'h5A.
   - frame_end pulses; miso_oe=0.
   - With SPI_PHY_BIT_ERR_EN defined, bit_err=1 until the next frame_start.
5. Reset asserted mid-byte (after 3 bits) and released with SS still low -> outputs 0; no frame_start until an SS high->low cycle; the next full byte 8'hC3 is received correctly.
6. SS rise and the 8th SCLK rise arrive at the pins on the same clk edge -> no rx_valid; frame_end pulses.
